// File: rtl/ram16k_arbiter.sv
// ram16k_arbiter
//   Shares one single-port ram16k (1-cycle registered read) between two
//   requesters. Port A is the CPU side and port B the loader/DMA/debug side.
//   Conflicts are resolved round-robin. B can lock the RAM for short bursts.
//   After MAX_LOCK consecutive locked B grants, A is served once.
//   Each read result is steered back to the port that issued it, with a
//   valid strobe. When the upper 8k bank is absent (HAS_HIGH=0), accesses
//   with addr[AW-1]=1 are acked but never reach the RAM. They also set the
//   sticky oor_err flag.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata      port A request (held until a_ack)
//   a_ack                          port A accepted this cycle (combinational)
//   a_rvalid/a_rdata               port A read return (cycle after ack)
//   b_req/b_we/b_addr/b_wdata      port B request (held until b_ack)
//   b_lock                         port B keeps priority while high
//   b_ack/b_rvalid/b_rdata         port B handshake and read return
//   ram_addr/ram_data_in/ram_we/ram_re/ram_data_out   ram16k interface
//   oor_err                        sticky out-of-range flag
module ram16k_arbiter #(
  parameter int AW       = 13,
  parameter int DW       = 16,
  parameter int HAS_HIGH = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic          b_lock,
  output logic          b_ack,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_data_out,
  output logic          oor_err
);

  localparam int             LCW      = $clog2(MAX_LOCK) + 1;
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  logic           last_q, last_d;          // 1 = B was served last
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]     rd_owner_q, rd_owner_d;
  logic           rd_oor_q, rd_oor_d;      // pending read was out of range
  logic           oor_err_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;

  logic           lock_full;
  logic           b_wins;
  logic           gnt;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           oor;

  // b_wins only decides a conflict. A lone requester is always granted.
  // Acks are gated by rst_n so nothing is granted while reset is asserted.
  always_comb begin
    lock_full = (lock_cnt_q == LOCK_MAX);
    if (b_lock) b_wins = !lock_full;
    else        b_wins = !last_q;
    a_ack = rst_n && a_req && !(b_req && b_wins);
    b_ack = rst_n && b_req && !(a_req && !b_wins);
  end

  always_comb begin
    gnt       = a_ack || b_ack;
    sel_we    = a_ack ? a_we    : b_we;
    sel_addr  = a_ack ? a_addr  : b_addr;
    sel_wdata = a_ack ? a_wdata : b_wdata;
    oor       = (HAS_HIGH == 0) && sel_addr[AW-1];

    ram_we      = gnt && sel_we && !oor;
    ram_re      = gnt && !sel_we && !oor;
    // Idle cycles keep presenting the last granted address and data.
    ram_addr    = gnt ? sel_addr  : addr_q;
    ram_data_in = gnt ? sel_wdata : wdata_q;
    oor_err     = oor_err_q || (gnt && oor);
  end

  always_comb begin
    last_d = last_q;
    if (a_ack)      last_d = 1'b0;
    else if (b_ack) last_d = 1'b1;

    // The counter saturates at MAX_LOCK. It stays there while A is idle,
    // so A is served as soon as it asks.
    lock_cnt_d = lock_cnt_q;
    if (a_ack || !b_lock)      lock_cnt_d = '0;
    else if (b_ack && !lock_full) lock_cnt_d = lock_cnt_q + LCW'(1);

    rd_owner_d = OWN_NONE;
    if (a_ack && !a_we)      rd_owner_d = OWN_A;
    else if (b_ack && !b_we) rd_owner_d = OWN_B;
    rd_oor_d = oor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rd_owner_q <= OWN_NONE;
      rd_oor_q   <= 1'b0;
      oor_err_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
      oor_err_q  <= oor_err;
      addr_q     <= ram_addr;
      wdata_q    <= ram_data_in;
    end
  end

  // Read data comes straight from the RAM. It is zero unless it belongs to
  // this port, and also zero when the read hit the absent bank.
  always_comb begin
    a_rvalid = (rd_owner_q == OWN_A);
    b_rvalid = (rd_owner_q == OWN_B);
    a_rdata  = (a_rvalid && !rd_oor_q) ? ram_data_out : '0;
    b_rdata  = (b_rvalid && !rd_oor_q) ? ram_data_out : '0;
  end

endmodule

// File: tb/tb_ram16k_arbiter.sv
module tb_ram16k_arbiter;

  localparam int MAXL = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we, b_lock;
  logic [12:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;

  // index 0: full 16k build, index 1: HAS_HIGH=0 build
  logic [1:0]  a_ack_w, b_ack_w, a_rvalid_w, b_rvalid_w, ram_we_w, ram_re_w, oor_w;
  logic [15:0] a_rdata_w [2];
  logic [15:0] b_rdata_w [2];
  logic [15:0] ram_din_w [2];
  logic [15:0] ram_dout_w [2];
  logic [12:0] ram_addr_w [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram16k_arbiter #(.AW(13), .DW(16), .HAS_HIGH(1), .MAX_LOCK(MAXL)) u_full (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack_w[0]), .a_rvalid(a_rvalid_w[0]), .a_rdata(a_rdata_w[0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock),
    .b_ack(b_ack_w[0]), .b_rvalid(b_rvalid_w[0]), .b_rdata(b_rdata_w[0]),
    .ram_addr(ram_addr_w[0]), .ram_data_in(ram_din_w[0]),
    .ram_we(ram_we_w[0]), .ram_re(ram_re_w[0]),
    .ram_data_out(ram_dout_w[0]), .oor_err(oor_w[0])
  );

  ram16k_arbiter #(.AW(13), .DW(16), .HAS_HIGH(0), .MAX_LOCK(MAXL)) u_small (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack_w[1]), .a_rvalid(a_rvalid_w[1]), .a_rdata(a_rdata_w[1]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock),
    .b_ack(b_ack_w[1]), .b_rvalid(b_rvalid_w[1]), .b_rdata(b_rdata_w[1]),
    .ram_addr(ram_addr_w[1]), .ram_data_in(ram_din_w[1]),
    .ram_we(ram_we_w[1]), .ram_re(ram_re_w[1]),
    .ram_data_out(ram_dout_w[1]), .oor_err(oor_w[1])
  );

  // ram16k behavioural models, one per build
  logic [15:0] ram_mem [2][8192];
  // reference memory of the checking model
  logic [15:0] mdl_mem [2][8192];

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram_mem[0][i] = 16'(i) ^ 16'hA5A5;
      ram_mem[1][i] = 16'(i) ^ 16'hA5A5;
      mdl_mem[0][i] = 16'(i) ^ 16'hA5A5;
      mdl_mem[1][i] = 16'(i) ^ 16'hA5A5;
    end
    ram_mem[0][16'h0010] = 16'hBEEF;
    ram_mem[1][16'h0010] = 16'hBEEF;
    mdl_mem[0][16'h0010] = 16'hBEEF;
    mdl_mem[1][16'h0010] = 16'hBEEF;
    ram_dout_w[0] = 16'h0;
    ram_dout_w[1] = 16'h0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_we_w[i]) ram_mem[i][ram_addr_w[i]] <= ram_din_w[i];
      if (ram_re_w[i]) ram_dout_w[i] <= ram_mem[i][ram_addr_w[i]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- checking model ----------------
  int          m_last [2];   // 0 = A served last, 1 = B served last
  int          m_lcnt [2];
  int          m_pown [2];   // pending read owner: 0 none, 1 A, 2 B
  logic [15:0] m_pdat [2];
  logic [12:0] m_haddr [2];
  logic [15:0] m_hdata [2];
  bit          m_oor [2];

  always @(negedge clk) begin
    bit          ga, gb, g, we, oor, hh;
    logic [12:0] ad;
    logic [15:0] wd;
    bit          e_aack, e_back, e_arv, e_brv, e_we, e_re, e_oor;
    logic [15:0] e_ard, e_brd, e_din;
    logic [12:0] e_addr;
    for (int i = 0; i < 2; i++) begin
      hh = (i == 0);
      if (!rst_n) begin
        e_aack = 0; e_back = 0; e_arv = 0; e_brv = 0; e_we = 0; e_re = 0; e_oor = 0;
        e_ard = 0; e_brd = 0; e_din = 0; e_addr = 0;
        m_last[i] = 1; m_lcnt[i] = 0; m_pown[i] = 0; m_pdat[i] = 0;
        m_haddr[i] = 0; m_hdata[i] = 0; m_oor[i] = 0;
      end else begin
        ga = 0; gb = 0;
        if (a_req && !b_req) ga = 1;
        else if (b_req && !a_req) gb = 1;
        else if (a_req && b_req) begin
          if (b_lock) begin
            if (m_lcnt[i] < MAXL) gb = 1; else ga = 1;
          end else if (m_last[i] == 1) ga = 1;
          else gb = 1;
        end
        g   = ga || gb;
        we  = ga ? a_we : b_we;
        ad  = ga ? a_addr : b_addr;
        wd  = ga ? a_wdata : b_wdata;
        oor = !hh && (ad >= 13'h1000);

        e_aack = ga; e_back = gb;
        e_arv  = (m_pown[i] == 1);
        e_brv  = (m_pown[i] == 2);
        e_ard  = e_arv ? m_pdat[i] : 16'h0;
        e_brd  = e_brv ? m_pdat[i] : 16'h0;
        e_we   = g && we && !oor;
        e_re   = g && !we && !oor;
        e_addr = g ? ad : m_haddr[i];
        e_din  = g ? wd : m_hdata[i];
        e_oor  = m_oor[i] || (g && oor);

        m_pown[i] = 0;
        if (g && !we) begin
          m_pown[i] = ga ? 1 : 2;
          m_pdat[i] = oor ? 16'h0 : mdl_mem[i][ad];
        end
        if (g && we && !oor) mdl_mem[i][ad] = wd;
        if (ga) m_last[i] = 0;
        if (gb) m_last[i] = 1;
        if (ga || !b_lock) m_lcnt[i] = 0;
        else if (gb && m_lcnt[i] < MAXL) m_lcnt[i]++;
        m_haddr[i] = e_addr;
        m_hdata[i] = e_din;
        m_oor[i]   = e_oor;
      end
      chk($sformatf("a_ack[%0d]", i),    32'(a_ack_w[i]),    32'(e_aack));
      chk($sformatf("b_ack[%0d]", i),    32'(b_ack_w[i]),    32'(e_back));
      chk($sformatf("a_rvalid[%0d]", i), 32'(a_rvalid_w[i]), 32'(e_arv));
      chk($sformatf("b_rvalid[%0d]", i), 32'(b_rvalid_w[i]), 32'(e_brv));
      chk($sformatf("a_rdata[%0d]", i),  32'(a_rdata_w[i]),  32'(e_ard));
      chk($sformatf("b_rdata[%0d]", i),  32'(b_rdata_w[i]),  32'(e_brd));
      chk($sformatf("ram_we[%0d]", i),   32'(ram_we_w[i]),   32'(e_we));
      chk($sformatf("ram_re[%0d]", i),   32'(ram_re_w[i]),   32'(e_re));
      chk($sformatf("ram_addr[%0d]", i), 32'(ram_addr_w[i]), 32'(e_addr));
      chk($sformatf("ram_din[%0d]", i),  32'(ram_din_w[i]),  32'(e_din));
      chk($sformatf("oor_err[%0d]", i),  32'(oor_w[i]),      32'(e_oor));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit ar, input bit aw, input logic [12:0] aa, input logic [15:0] ad,
                     input bit br, input bit bw, input logic [12:0] ba, input logic [15:0] bd,
                     input bit bl);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
  endtask

  task automatic idle();
    drv(0, 0, 13'h0, 16'h0, 0, 0, 13'h0, 16'h0, 0);
  endtask

  initial begin
    int na, nb;
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ack", 32'(a_ack_w[0]), 32'h0);
    chk("rst_oor", 32'(oor_w[1]), 32'h0);
    step();
    rst_n = 1'b1;

    // lone A read of the preloaded word
    drv(1, 0, 13'h0010, 16'h0, 0, 0, 13'h0, 16'h0, 0);
    @(negedge clk);
    chk("t1_a_ack", 32'(a_ack_w[0]), 32'h1);
    chk("t1_b_ack", 32'(b_ack_w[0]), 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("t1_a_rvalid", 32'(a_rvalid_w[0]), 32'h1);
    chk("t1_a_rdata", 32'(a_rdata_w[0]), 32'hBEEF);
    chk("t1_b_rvalid", 32'(b_rvalid_w[0]), 32'h0);
    chk("t1_addr_hold", 32'(ram_addr_w[0]), 32'h0010);

    // fresh reset so the first conflict starts from last=B
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // continuous conflict: strict alternation starting with A
    na = 0; nb = 0;
    for (int k = 0; k < 6; k++) begin
      drv(1, 0, 13'(13'h0020 + na), 16'h0, 1, 0, 13'(13'h0040 + nb), 16'h0, 0);
      @(negedge clk);
      chk($sformatf("t2_a_ack_%0d", k), 32'(a_ack_w[0]), 32'((k % 2) == 0));
      chk($sformatf("t2_b_ack_%0d", k), 32'(b_ack_w[0]), 32'((k % 2) == 1));
      if (k == 1) chk("t2_a_rdata", 32'(a_rdata_w[0]), 32'hA585);
      na += int'(a_ack_w[0]);
      nb += int'(b_ack_w[0]);
      step();
    end
    idle();
    step();

    // locked burst: 8 B grants, then A once, then B again
    na = 0; nb = 0;
    for (int k = 0; k < 10; k++) begin
      drv(1, 0, 13'(13'h0060 + na), 16'h0, 1, 0, 13'(13'h0080 + nb), 16'h0, 1);
      @(negedge clk);
      chk($sformatf("t3_b_ack_%0d", k), 32'(b_ack_w[0]), 32'(k != 8));
      chk($sformatf("t3_a_ack_%0d", k), 32'(a_ack_w[0]), 32'(k == 8));
      na += int'(a_ack_w[0]);
      nb += int'(b_ack_w[0]);
      step();
    end
    idle();
    step();

    // A write, B read-back of the same word on the next cycle
    drv(1, 1, 13'h0FFF, 16'h1234, 0, 0, 13'h0, 16'h0, 0);
    @(negedge clk);
    chk("t4_a_ack", 32'(a_ack_w[0]), 32'h1);
    chk("t4_ram_we", 32'(ram_we_w[0]), 32'h1);
    step();
    drv(0, 0, 13'h0, 16'h0, 1, 0, 13'h0FFF, 16'h0, 0);
    @(negedge clk);
    chk("t4_b_ack", 32'(b_ack_w[0]), 32'h1);
    chk("t4_b_rvalid_early", 32'(b_rvalid_w[0]), 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("t4_b_rvalid", 32'(b_rvalid_w[0]), 32'h1);
    chk("t4_b_rdata_full", 32'(b_rdata_w[0]), 32'h1234);
    chk("t4_b_rdata_small", 32'(b_rdata_w[1]), 32'h1234);
    step();

    // upper bank: real in the full build, blocked in the small one
    drv(0, 0, 13'h0, 16'h0, 1, 1, 13'h1000, 16'h5555, 0);
    @(negedge clk);
    chk("t5_b_ack_small", 32'(b_ack_w[1]), 32'h1);
    chk("t5_we_small", 32'(ram_we_w[1]), 32'h0);
    chk("t5_we_full", 32'(ram_we_w[0]), 32'h1);
    chk("t5_oor_small", 32'(oor_w[1]), 32'h1);
    chk("t5_oor_full", 32'(oor_w[0]), 32'h0);
    step();
    drv(0, 0, 13'h0, 16'h0, 1, 0, 13'h1000, 16'h0, 0);
    @(negedge clk);
    chk("t5_rd_ack_small", 32'(b_ack_w[1]), 32'h1);
    chk("t5_re_small", 32'(ram_re_w[1]), 32'h0);
    step();
    drv(0, 0, 13'h0, 16'h0, 1, 0, 13'h0000, 16'h0, 0);
    @(negedge clk);
    chk("t5_rvalid_small", 32'(b_rvalid_w[1]), 32'h1);
    chk("t5_rdata_small", 32'(b_rdata_w[1]), 32'h0000);
    chk("t5_rdata_full", 32'(b_rdata_w[0]), 32'h5555);
    step();
    idle();
    @(negedge clk);
    chk("t5_addr0_small", 32'(b_rdata_w[1]), 32'hA5A5);
    chk("t5_oor_sticky", 32'(oor_w[1]), 32'h1);
    step();

    // reset between an A read ack and its return
    drv(1, 0, 13'h0010, 16'h0, 0, 0, 13'h0, 16'h0, 0);
    @(negedge clk);
    chk("t6_a_ack", 32'(a_ack_w[0]), 32'h1);
    #2;
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_no_rvalid", 32'(a_rvalid_w[0]), 32'h0);
    chk("t6_oor_clr", 32'(oor_w[1]), 32'h0);
    chk("t6_addr_rst", 32'(ram_addr_w[0]), 32'h0);
    step();
    drv(1, 0, 13'h0011, 16'h0, 1, 0, 13'h0012, 16'h0, 0);
    @(negedge clk);
    chk("t6_a_first", 32'(a_ack_w[0]), 32'h1);
    chk("t6_b_wait", 32'(b_ack_w[0]), 32'h0);
    step();
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
